multicycle_control_unit: RTL and testbench

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

---
 rtl/riscv_ctrl_pkg.sv | 43 ++++
 rtl/opcode_class_decoder.sv | 29 ++
 rtl/multicycle_control_unit.sv | 149 ++++++++++++++
 tb/tb_multicycle_control_unit.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control unit: opcodes, FSM states,
// instruction classes and the imm_sel / pc_src / wb_sel output codes.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_I      = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_TRAP      = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        CLS_NONE, CLS_R, CLS_I, CLS_LOAD, CLS_STORE,
        CLS_BRANCH, CLS_LUI, CLS_JAL, CLS_JALR
    } instr_class_e;

    localparam logic [2:0] IMM_NONE = 3'd0;
    localparam logic [2:0] IMM_I    = 3'd1;
    localparam logic [2:0] IMM_S    = 3'd2;
    localparam logic [2:0] IMM_B    = 3'd3;
    localparam logic [2:0] IMM_U    = 3'd4;
    localparam logic [2:0] IMM_J    = 3'd5;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_TARGET = 2'b01;
    localparam logic [1:0] PC_ALU    = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

endpackage

// File: rtl/opcode_class_decoder.sv
// Purely combinational opcode classifier: instruction class, immediate format
// and a legal flag for the eight supported RV32I major opcodes.
module opcode_class_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0]   op_i,
    output instr_class_e cls_o,
    output logic [2:0]   imm_sel_o,
    output logic         legal_o
);

    always_comb begin
        cls_o     = CLS_NONE;
        imm_sel_o = IMM_NONE;
        legal_o   = 1'b1;
        case (op_i)
            OP_R:      cls_o = CLS_R;
            OP_I:      begin cls_o = CLS_I;      imm_sel_o = IMM_I; end
            OP_LOAD:   begin cls_o = CLS_LOAD;   imm_sel_o = IMM_I; end
            OP_STORE:  begin cls_o = CLS_STORE;  imm_sel_o = IMM_S; end
            OP_BRANCH: begin cls_o = CLS_BRANCH; imm_sel_o = IMM_B; end
            OP_LUI:    begin cls_o = CLS_LUI;    imm_sel_o = IMM_U; end
            OP_JAL:    begin cls_o = CLS_JAL;    imm_sel_o = IMM_J; end
            OP_JALR:   begin cls_o = CLS_JALR;   imm_sel_o = IMM_I; end
            default:   legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control FSM (FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK/TRAP).
// Define MEM_READY_EN to make FETCH and MEMORY wait on mem_ready_i.
module multicycle_control_unit
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op_i,
    input  logic       branch_cond_i,
    input  logic       mem_ready_i,
    output logic       ir_write_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       pc_write_o,
    output logic [1:0] pc_src_o,
    output logic [2:0] imm_sel_o,
    output logic       alu_src_b_o,
    output logic       reg_write_o,
    output logic [1:0] wb_sel_o,
    output logic [2:0] state_o,
    output logic       illegal_o
);

    state_e       state_q, state_d;
    logic         illegal_q, illegal_d;
    instr_class_e cls;
    logic [2:0]   dec_imm_sel;
    logic         dec_legal;
    logic         mem_ready;

    // Memory handshake: the access requested in FETCH/MEMORY completes in the
    // cycle mem_ready is high; until then the strobes stay stable and the
    // state holds. Without the option the memory is treated as zero-wait.
`ifdef MEM_READY_EN
    assign mem_ready = mem_ready_i;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready_i;
    assign mem_ready        = 1'b1;
`endif

    opcode_class_decoder u_decoder (
        .op_i      (op_i),
        .cls_o     (cls),
        .imm_sel_o (dec_imm_sel),
        .legal_o   (dec_legal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        illegal_d   = illegal_q;
        ir_write_o  = 1'b0;
        mem_read_o  = 1'b0;
        mem_write_o = 1'b0;
        pc_write_o  = 1'b0;
        pc_src_o    = PC_PLUS4;
        imm_sel_o   = IMM_NONE;
        alu_src_b_o = 1'b0;
        reg_write_o = 1'b0;
        wb_sel_o    = WB_ALU;

        case (state_q)
            ST_FETCH: begin
                mem_read_o = 1'b1;
                ir_write_o = mem_ready;
                if (mem_ready) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                imm_sel_o = dec_imm_sel;
                if (dec_legal) begin
                    state_d = ST_EXECUTE;
                end else begin
                    state_d   = ST_TRAP;
                    illegal_d = 1'b1;
                end
            end
            ST_EXECUTE: begin
                imm_sel_o   = dec_imm_sel;
                alu_src_b_o = !(cls == CLS_R || cls == CLS_BRANCH);
                case (cls)
                    CLS_LOAD, CLS_STORE: state_d = ST_MEMORY;
                    CLS_BRANCH: begin
                        // Branch resolves here: PC+4 or target, no writeback.
                        pc_write_o = 1'b1;
                        pc_src_o   = branch_cond_i ? PC_TARGET : PC_PLUS4;
                        state_d    = ST_FETCH;
                    end
                    default: state_d = ST_WRITEBACK;
                endcase
            end
            ST_MEMORY: begin
                case (cls)
                    CLS_LOAD: begin
                        mem_read_o = 1'b1;
                        if (mem_ready) state_d = ST_WRITEBACK;
                    end
                    CLS_STORE: begin
                        mem_write_o = 1'b1;
                        pc_write_o  = mem_ready;
                        if (mem_ready) state_d = ST_FETCH;
                    end
                    default: state_d = ST_FETCH;
                endcase
            end
            ST_WRITEBACK: begin
                reg_write_o = 1'b1;
                pc_write_o  = 1'b1;
                case (cls)
                    CLS_LOAD: wb_sel_o = WB_MEM;
                    CLS_JAL:  begin wb_sel_o = WB_PC4; pc_src_o = PC_TARGET; end
                    CLS_JALR: begin wb_sel_o = WB_PC4; pc_src_o = PC_ALU;    end
                    default:  ;
                endcase
                state_d = ST_FETCH;
            end
            ST_TRAP: begin
                illegal_d = 1'b1;
            end
            default: state_d = ST_FETCH;
        endcase

        // Reset aborts whatever is in flight: nothing may strobe this cycle.
        if (reset) begin
            ir_write_o  = 1'b0;
            mem_read_o  = 1'b0;
            mem_write_o = 1'b0;
            pc_write_o  = 1'b0;
            pc_src_o    = PC_PLUS4;
            imm_sel_o   = IMM_NONE;
            alu_src_b_o = 1'b0;
            reg_write_o = 1'b0;
            wb_sel_o    = WB_ALU;
        end
    end

    assign state_o   = reset ? 3'd0 : state_q;
    assign illegal_o = illegal_q & ~reset;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: per-cycle expected output
// vectors are queued with their stimulus and compared as the FSM steps.
module tb_multicycle_control_unit;

    localparam int W = 17;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op_i;
    logic       branch_cond_i;
    logic       mem_ready_i;
    logic       ir_write_o, mem_read_o, mem_write_o, pc_write_o;
    logic [1:0] pc_src_o;
    logic [2:0] imm_sel_o;
    logic       alu_src_b_o, reg_write_o;
    logic [1:0] wb_sel_o;
    logic [2:0] state_o;
    logic       illegal_o;
    logic [W-1:0] obs;

    typedef struct {
        logic [6:0] op;
        logic       cond;
        logic       rdy;
    } stim_t;

    stim_t        stim_q[$];
    logic [W-1:0] exp_q[$];
    int           n_checks = 0;
    int           n_errors = 0;

    always #5 clk = ~clk;

    multicycle_control_unit dut (
        .clk           (clk),
        .reset         (reset),
        .op_i          (op_i),
        .branch_cond_i (branch_cond_i),
        .mem_ready_i   (mem_ready_i),
        .ir_write_o    (ir_write_o),
        .mem_read_o    (mem_read_o),
        .mem_write_o   (mem_write_o),
        .pc_write_o    (pc_write_o),
        .pc_src_o      (pc_src_o),
        .imm_sel_o     (imm_sel_o),
        .alu_src_b_o   (alu_src_b_o),
        .reg_write_o   (reg_write_o),
        .wb_sel_o      (wb_sel_o),
        .state_o       (state_o),
        .illegal_o     (illegal_o)
    );

    assign obs = {state_o, illegal_o, ir_write_o, mem_read_o, mem_write_o, pc_write_o,
                  pc_src_o, imm_sel_o, alu_src_b_o, reg_write_o, wb_sel_o};

    // Expected vector: state, illegal, ir_write, mem_read, mem_write, pc_write,
    // pc_src, imm_sel, alu_src_b, reg_write, wb_sel.
    function automatic logic [W-1:0] mk(input int st, input int ill, input int irw,
                                        input int mr, input int mw, input int pcw,
                                        input int pcs, input int imm, input int asb,
                                        input int rw, input int wb);
        return {st[2:0], ill[0], irw[0], mr[0], mw[0], pcw[0],
                pcs[1:0], imm[2:0], asb[0], rw[0], wb[1:0]};
    endfunction

    function automatic logic default_rdy();
`ifdef MEM_READY_EN
        return 1'b1;
`else
        return 1'($urandom_range(0, 1));
`endif
    endfunction

    task automatic push(input logic [6:0] op, input logic cond, input logic rdy,
                        input logic [W-1:0] vec);
        stim_t s;
        s.op = op; s.cond = cond; s.rdy = rdy;
        stim_q.push_back(s);
        exp_q.push_back(vec);
    endtask

    // Reference behaviour of one instruction, written from the opcode table.
    task automatic push_instr(input logic [6:0] op, input logic cond);
        int imm, asb, pcs, wb;
        logic legal;
        legal = 1'b1;
        case (op)
            7'h13, 7'h03, 7'h67: imm = 1;
            7'h23: imm = 2;
            7'h63: imm = 3;
            7'h37: imm = 4;
            7'h6F: imm = 5;
            7'h33: imm = 0;
            default: begin imm = 0; legal = 1'b0; end
        endcase
        asb = (op == 7'h33 || op == 7'h63) ? 0 : 1;
        pcs = (op == 7'h6F) ? 1 : (op == 7'h67) ? 2 : 0;
        wb  = (op == 7'h03) ? 1 : (op == 7'h6F || op == 7'h67) ? 2 : 0;
        // op_i is a don't-care during FETCH, so scramble it there.
        push(7'($urandom_range(0, 127)), cond, default_rdy(), mk(0,0,1,1,0,0,0,0,0,0,0));
        push(op, cond, default_rdy(), mk(1,0,0,0,0,0,0,imm,0,0,0));
        if (!legal) begin
            for (int i = 0; i < 10; i++)
                push(op, cond, default_rdy(), mk(5,1,0,0,0,0,0,0,0,0,0));
            return;
        end
        if (op == 7'h63) begin
            push(op, cond, default_rdy(), mk(2,0,0,0,0,1,cond ? 1 : 0,imm,asb,0,0));
            return;
        end
        push(op, cond, default_rdy(), mk(2,0,0,0,0,0,0,imm,asb,0,0));
        if (op == 7'h23) begin
            push(op, cond, default_rdy(), mk(3,0,0,0,1,1,0,0,0,0,0));
            return;
        end
        if (op == 7'h03)
            push(op, cond, default_rdy(), mk(3,0,0,1,0,0,0,0,0,0,0));
        push(op, cond, default_rdy(), mk(4,0,0,0,0,1,pcs,0,0,1,wb));
    endtask

    // Scoreboard drain: one queued cycle per falling edge, compared before the
    // next rising edge consumes the inputs.
    task automatic run_queue(input string name);
        stim_t        s;
        logic [W-1:0] e;
        int           cyc;
        cyc = 0;
        while (exp_q.size() > 0) begin
            s = stim_q.pop_front();
            e = exp_q.pop_front();
            op_i = s.op; branch_cond_i = s.cond; mem_ready_i = s.rdy;
            #1;
            n_checks++;
            if (obs !== e) begin
                n_errors++;
                $display("FAIL %s cycle %0d: got %05h expected %05h", name, cyc, obs, e);
            end
            n_checks++;
            if (((mem_read_o & mem_write_o) | (reg_write_o & mem_write_o)) !== 1'b0) begin
                n_errors++;
                $display("FAIL %s_overlap cycle %0d: got rd=%b wr=%b rw=%b expected no overlap",
                         name, cyc, mem_read_o, mem_write_o, reg_write_o);
            end
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; op_i = 7'h33; branch_cond_i = 1'b1; mem_ready_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            n_checks++;
            if (obs !== '0) begin
                n_errors++;
                $display("FAIL reset_outputs cycle %0d: got %05h expected 00000", i, obs);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_r_type();
        push_instr(7'h33, 1'b0);
        run_queue("r_type");
        #1;
        n_checks++;
        if (state_o !== 3'd0) begin
            n_errors++;
            $display("FAIL r_return_fetch: got state %0d expected 0", state_o);
        end
    endtask

    task automatic test_branch();
        push_instr(7'h63, 1'b1);
        push_instr(7'h63, 1'b0);
        run_queue("branch");
    endtask

    task automatic test_all_opcodes();
        push_instr(7'h13, 1'b0);
        push_instr(7'h03, 1'b1);
        push_instr(7'h23, 1'b0);
        push_instr(7'h37, 1'b1);
        push_instr(7'h6F, 1'b0);
        push_instr(7'h67, 1'b1);
        run_queue("opcodes");
    endtask

    task automatic test_back_to_back();
        logic [6:0] ops [8];
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h6F, 7'h67};
        for (int i = 0; i < 24; i++)
            push_instr(ops[$urandom_range(0, 7)], 1'($urandom_range(0, 1)));
        run_queue("back_to_back");
    endtask

`ifdef MEM_READY_EN
    task automatic test_mem_stall();
        push(7'h03, 1'b0, 1'b0, mk(0,0,0,1,0,0,0,0,0,0,0));
        push(7'h03, 1'b0, 1'b1, mk(0,0,1,1,0,0,0,0,0,0,0));
        push(7'h03, 1'b0, 1'b1, mk(1,0,0,0,0,0,0,1,0,0,0));
        push(7'h03, 1'b0, 1'b1, mk(2,0,0,0,0,0,0,1,1,0,0));
        push(7'h03, 1'b0, 1'b0, mk(3,0,0,1,0,0,0,0,0,0,0));
        push(7'h03, 1'b0, 1'b0, mk(3,0,0,1,0,0,0,0,0,0,0));
        push(7'h03, 1'b0, 1'b1, mk(3,0,0,1,0,0,0,0,0,0,0));
        push(7'h03, 1'b0, 1'b1, mk(4,0,0,0,0,1,0,0,0,1,1));
        push(7'h23, 1'b0, 1'b1, mk(0,0,1,1,0,0,0,0,0,0,0));
        push(7'h23, 1'b0, 1'b1, mk(1,0,0,0,0,0,0,2,0,0,0));
        push(7'h23, 1'b0, 1'b1, mk(2,0,0,0,0,0,0,2,1,0,0));
        push(7'h23, 1'b0, 1'b0, mk(3,0,0,0,1,0,0,0,0,0,0));
        push(7'h23, 1'b0, 1'b1, mk(3,0,0,0,1,1,0,0,0,0,0));
        run_queue("mem_stall");
    endtask
`else
    task automatic test_ready_ignored();
        push_instr(7'h03, 1'b0);
        push_instr(7'h23, 1'b0);
        for (int i = 0; i < stim_q.size(); i++) stim_q[i].rdy = 1'b0;
        run_queue("ready_ignored");
    endtask
`endif

    task automatic test_reset_mid_store();
        push_instr(7'h23, 1'b0);
        void'(exp_q.pop_back());
        void'(stim_q.pop_back());
        run_queue("store_pre_reset");
        reset = 1'b1;
        #1;
        n_checks++;
        if (obs !== '0) begin
            n_errors++;
            $display("FAIL reset_in_memory: got %05h expected 00000 (mem_write_o=%b)", obs, mem_write_o);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if (state_o !== 3'd0) begin
            n_errors++;
            $display("FAIL reset_in_memory_state: got %0d expected 0", state_o);
        end
    endtask

    task automatic test_trap();
        push_instr(7'h7F, 1'b0);
        run_queue("trap");
        reset = 1'b1;
        #1;
        n_checks++;
        if (obs !== '0) begin
            n_errors++;
            $display("FAIL trap_reset_outputs: got %05h expected 00000", obs);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if ({state_o, illegal_o} !== 4'b0000) begin
            n_errors++;
            $display("FAIL trap_cleared: got state %0d illegal %b expected state 0 illegal 0",
                     state_o, illegal_o);
        end
        push_instr(7'h67, 1'b0);
        run_queue("after_trap_jalr");
    endtask

    initial begin
        test_reset();
        test_r_type();
        test_branch();
        test_all_opcodes();
        test_back_to_back();
`ifdef MEM_READY_EN
        test_mem_stall();
`else
        test_ready_ignored();
`endif
        test_reset_mid_store();
        test_trap();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
